register_writeback_unit: RTL and testbench

Drives the register file's single write port (WriteEn, rd1Adr, Rd1) and arbitrates between two sources: the in-order pipeline writeback and out-of-order long-latency results (divider, load miss). Late results are buffered in a small FIFO. A pending-register scoreboard answers the register-read stage's hazard queries so it can stall on RAW dependencies against in-flight long-latency ops. A starvation counter guarantees that late results eventually drain.

---
 rtl/register_writeback_unit_pkg.sv | 21 ++
 rtl/register_writeback_unit_fifo.sv | 53 +++++
 rtl/register_writeback_unit.sv | 137 +++++++++++++
 tb/tb_register_writeback_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/register_writeback_unit_pkg.sv
// rtl/register_writeback_unit_pkg.sv - shared types for the register writeback unit
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

package register_writeback_unit_pkg;

   localparam int RWU_REG_COUNT = 32;
   localparam int RWU_ADR_W     = $clog2(RWU_REG_COUNT);
   localparam int RWU_DATA_W    = `BIT_COUNT;

   // One buffered late result: destination register plus value
   typedef struct packed {
      logic [RWU_ADR_W-1:0]  adr;
      logic [RWU_DATA_W-1:0] data;
   } wb_entry_t;

   // One pending bit per architectural register
   typedef logic [RWU_REG_COUNT-1:0] pending_vec_t;

endpackage

// File: rtl/register_writeback_unit_fifo.sv
// rtl/register_writeback_unit_fifo.sv - late result FIFO with wrap-bit pointers
module late_result_fifo #(
   parameter int  DEPTH   = 4,
   parameter type entry_t = logic [7:0]
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  entry_t                 push_data,
   input  logic                   pop,
   output entry_t                 pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

   entry_t      mem_q [DEPTH];
   logic [PW:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0] rd_ptr_q, rd_ptr_d;
   logic        wr_en, rd_en;

   // Guard against overflow/underflow; the extra pointer bit tells full from empty
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
      count    = wr_ptr_q - rd_ptr_q;
      wr_en    = push && !full;
      rd_en    = pop && !empty;
      wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      pop_data = mem_q[rd_ptr_q[PW-1:0]];
   end

   // Pointer state; reset empties the FIFO
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage needs no reset; pointers define validity
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
   end

endmodule

// File: rtl/register_writeback_unit.sv
// rtl/register_writeback_unit.sv - register file write port arbiter with hazard scoreboard
module register_writeback_unit
   import register_writeback_unit_pkg::*;
#(
   parameter int REGISTER_COUNT = RWU_REG_COUNT,
   parameter int FIFO_DEPTH     = 4,
   parameter int STARVE_LIMIT   = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              wbValid,
   input  logic [$clog2(REGISTER_COUNT)-1:0] wbAdr,
   input  logic [`BIT_COUNT-1:0]             wbData,
   output logic                              wbStall,
   input  logic                              lateValid,
   output logic                              lateReady,
   input  logic [$clog2(REGISTER_COUNT)-1:0] lateAdr,
   input  logic [`BIT_COUNT-1:0]             lateData,
   input  logic                              issueValid,
   input  logic [$clog2(REGISTER_COUNT)-1:0] issueAdr,
   input  logic [$clog2(REGISTER_COUNT)-1:0] rs1Adr,
   input  logic [$clog2(REGISTER_COUNT)-1:0] rs2Adr,
   output logic                              rs1Pending,
   output logic                              rs2Pending,
   output logic                              WriteEn,
   output logic [$clog2(REGISTER_COUNT)-1:0] rd1Adr,
   output logic [`BIT_COUNT-1:0]             Rd1
);

   localparam int ADR_W = $clog2(REGISTER_COUNT);
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int SW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   wb_entry_t         late_entry, fifo_head;
   logic              late_push, fifo_pop, take_wb;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;

   logic              we_q, we_d;
   logic [ADR_W-1:0]  adr_q, adr_d;
   logic [`BIT_COUNT-1:0] data_q, data_d;
   logic              from_fifo_q, from_fifo_d;
   pending_vec_t      pending_q, pending_d;
   logic [SW-1:0]     starve_q, starve_d;

   late_result_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (wb_entry_t)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (late_push),
      .push_data (late_entry),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Handshake, stall and hazard outputs, all from registered state
   always_comb begin
      late_entry.adr  = lateAdr;
      late_entry.data = lateData;
      lateReady       = (fifo_count < CW'(FIFO_DEPTH));
      late_push       = lateValid && !fifo_full;
      wbStall         = (starve_q == STARVE_MAX);
      rs1Pending      = (rs1Adr != '0) && pending_q[rs1Adr];
      rs2Pending      = (rs2Adr != '0) && pending_q[rs2Adr];
      WriteEn         = we_q;
      rd1Adr          = adr_q;
      Rd1             = data_q;
   end

   // Source select: a starved FIFO beats the pipeline, otherwise the pipeline wins
   always_comb begin
      take_wb  = 1'b0;
      fifo_pop = 1'b0;
      if (wbStall && !fifo_empty) fifo_pop = 1'b1;
      else if (wbValid)           take_wb  = 1'b1;
      else if (!fifo_empty)       fifo_pop = 1'b1;
   end

   // Next write-port contents; writes to x0 still consume their source but never enable
   always_comb begin
      we_d        = 1'b0;
      adr_d       = '0;
      data_d      = '0;
      from_fifo_d = 1'b0;
      if (take_wb) begin
         we_d   = (wbAdr != '0);
         adr_d  = wbAdr;
         data_d = wbData;
      end else if (fifo_pop) begin
         we_d        = (fifo_head.adr != '0);
         adr_d       = fifo_head.adr;
         data_d      = fifo_head.data;
         from_fifo_d = 1'b1;
      end
   end

   // Scoreboard: clear on the committed late write, then a same-edge issue re-sets it
   always_comb begin
      pending_d = pending_q;
      if (we_q && from_fifo_q && pending_q[adr_q]) pending_d[adr_q] = 1'b0;
      if (issueValid && issueAdr != '0)            pending_d[issueAdr] = 1'b1;
      pending_d[0] = 1'b0;
   end

   // Starvation counter: counts edges where the FIFO waits, saturating at the limit
   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || fifo_pop)    starve_d = '0;
      else if (starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q        <= 1'b0;
         adr_q       <= '0;
         data_q      <= '0;
         from_fifo_q <= 1'b0;
         pending_q   <= '0;
         starve_q    <= '0;
      end else begin
         we_q        <= we_d;
         adr_q       <= adr_d;
         data_q      <= data_d;
         from_fifo_q <= from_fifo_d;
         pending_q   <= pending_d;
         starve_q    <= starve_d;
      end
   end

endmodule

// File: tb/tb_register_writeback_unit.sv
// tb/tb_register_writeback_unit.sv - directed self-checking bench for register_writeback_unit
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module tb_register_writeback_unit;

   logic                  clk;
   logic                  reset;
   logic                  wbValid;
   logic [4:0]            wbAdr;
   logic [`BIT_COUNT-1:0] wbData;
   logic                  wbStall;
   logic                  lateValid;
   logic                  lateReady;
   logic [4:0]            lateAdr;
   logic [`BIT_COUNT-1:0] lateData;
   logic                  issueValid;
   logic [4:0]            issueAdr;
   logic [4:0]            rs1Adr;
   logic [4:0]            rs2Adr;
   logic                  rs1Pending;
   logic                  rs2Pending;
   logic                  WriteEn;
   logic [4:0]            rd1Adr;
   logic [`BIT_COUNT-1:0] Rd1;

   int n_tests;
   int n_fail;

   register_writeback_unit dut (
      .clk        (clk),
      .reset      (reset),
      .wbValid    (wbValid),
      .wbAdr      (wbAdr),
      .wbData     (wbData),
      .wbStall    (wbStall),
      .lateValid  (lateValid),
      .lateReady  (lateReady),
      .lateAdr    (lateAdr),
      .lateData   (lateData),
      .issueValid (issueValid),
      .issueAdr   (issueAdr),
      .rs1Adr     (rs1Adr),
      .rs2Adr     (rs2Adr),
      .rs1Pending (rs1Pending),
      .rs2Pending (rs2Pending),
      .WriteEn    (WriteEn),
      .rd1Adr     (rd1Adr),
      .Rd1        (Rd1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_wr(input string tag, input logic we, input logic [4:0] adr, input logic [31:0] data);
      check({tag, "_we"}, 64'(WriteEn), 64'(we));
      check({tag, "_adr"}, 64'(rd1Adr), 64'(adr));
      check({tag, "_data"}, 64'(Rd1), 64'(data));
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      reset      = 1'b0;
      wbValid    = 1'b0;
      wbAdr      = '0;
      wbData     = '0;
      lateValid  = 1'b0;
      lateAdr    = '0;
      lateData   = '0;
      issueValid = 1'b0;
      issueAdr   = '0;
      rs1Adr     = '0;
      rs2Adr     = '0;

      // Reset state
      #2 reset = 1'b1;
      #1;
      check_wr("rst", 1'b0, 5'd0, 32'h0);
      check("rst_ready", 64'(lateReady), 64'd1);
      check("rst_stall", 64'(wbStall), 64'd0);
      check("rst_pend", 64'(rs1Pending), 64'd0);
      tick(2);
      reset = 1'b0;
      tick(1);
      check("idle_we", 64'(WriteEn), 64'd0);

      // Pipeline only: one-cycle write, then idle
      wbValid = 1'b1; wbAdr = 5'd5; wbData = 32'h1234;
      tick(1);
      wbValid = 1'b0;
      check_wr("wb", 1'b1, 5'd5, 32'h1234);
      tick(1);
      check("wb_after_we", 64'(WriteEn), 64'd0);

      // Late path with scoreboard
      issueValid = 1'b1; issueAdr = 5'd7;
      tick(1);
      issueValid = 1'b0;
      rs1Adr = 5'd7; rs2Adr = 5'd0;
      #1;
      check("sb_set", 64'(rs1Pending), 64'd1);
      check("sb_x0", 64'(rs2Pending), 64'd0);
      lateValid = 1'b1; lateAdr = 5'd7; lateData = 32'hBEEF;
      tick(1);
      lateValid = 1'b0;
      check("late_no_bypass", 64'(WriteEn), 64'd0);
      tick(1);
      check_wr("late", 1'b1, 5'd7, 32'hBEEF);
      check("sb_hold", 64'(rs1Pending), 64'd1);
      tick(1);
      check("sb_clear", 64'(rs1Pending), 64'd0);
      check("late_after_we", 64'(WriteEn), 64'd0);

      // FIFO full while the pipeline owns the port
      wbValid = 1'b1; wbAdr = 5'd9; wbData = 32'h11;
      lateValid = 1'b1; lateAdr = 5'd10; lateData = 32'hA0;
      tick(1);
      check_wr("full_wb", 1'b1, 5'd9, 32'h11);
      lateAdr = 5'd11; lateData = 32'hA1;
      tick(1);
      lateAdr = 5'd12; lateData = 32'hA2;
      tick(1);
      lateAdr = 5'd13; lateData = 32'hA3;
      tick(1);
      check("full_ready0", 64'(lateReady), 64'd0);
      lateAdr = 5'd14; lateData = 32'hA4;
      tick(1);
      check("full_held", 64'(lateReady), 64'd0);
      check("full_nostall", 64'(wbStall), 64'd0);
      wbValid = 1'b0;
      tick(1);
      check_wr("drain0", 1'b1, 5'd10, 32'hA0);
      check("drain_ready", 64'(lateReady), 64'd1);
      tick(1);
      lateValid = 1'b0;
      check_wr("drain1", 1'b1, 5'd11, 32'hA1);
      tick(1);
      check_wr("drain2", 1'b1, 5'd12, 32'hA2);
      tick(1);
      check_wr("drain3", 1'b1, 5'd13, 32'hA3);
      tick(1);
      check_wr("drain4", 1'b1, 5'd14, 32'hA4);
      tick(1);
      check("drain_empty", 64'(WriteEn), 64'd0);

      // Starvation: one buffered entry against a continuous pipeline
      wbValid = 1'b1; wbAdr = 5'd21; wbData = 32'h22;
      lateValid = 1'b1; lateAdr = 5'd20; lateData = 32'hC0;
      tick(1);
      lateValid = 1'b0;
      tick(7);
      check("starve_7", 64'(wbStall), 64'd0);
      tick(1);
      check("starve_8", 64'(wbStall), 64'd1);
      check_wr("starve_wb", 1'b1, 5'd21, 32'h22);
      tick(1);
      check_wr("starve_pop", 1'b1, 5'd20, 32'hC0);
      check("starve_drop", 64'(wbStall), 64'd0);
      tick(1);
      wbValid = 1'b0;
      check_wr("starve_resume", 1'b1, 5'd21, 32'h22);
      tick(1);

      // Late write to x0 is consumed but never enabled
      lateValid = 1'b1; lateAdr = 5'd0; lateData = 32'hDEAD;
      tick(1);
      lateValid = 1'b0;
      check("x0_accept_we", 64'(WriteEn), 64'd0);
      tick(1);
      check("x0_pop_we", 64'(WriteEn), 64'd0);
      check("x0_ready", 64'(lateReady), 64'd1);
      tick(1);
      check("x0_gone_we", 64'(WriteEn), 64'd0);

      // Issue to 3 on the same edge its previous late write commits: set wins
      issueValid = 1'b1; issueAdr = 5'd3;
      tick(1);
      issueValid = 1'b0;
      rs1Adr = 5'd3;
      lateValid = 1'b1; lateAdr = 5'd3; lateData = 32'h33;
      tick(1);
      lateValid = 1'b0;
      tick(1);
      check_wr("coll_wr", 1'b1, 5'd3, 32'h33);
      issueValid = 1'b1; issueAdr = 5'd3;
      tick(1);
      issueValid = 1'b0;
      check("coll_pend", 64'(rs1Pending), 64'd1);

      // Asynchronous reset while draining three entries
      wbValid = 1'b1; wbAdr = 5'd9; wbData = 32'h55;
      lateValid = 1'b1; lateAdr = 5'd15; lateData = 32'hD0;
      tick(1);
      lateAdr = 5'd16; lateData = 32'hD1;
      tick(1);
      lateAdr = 5'd17; lateData = 32'hD2;
      tick(1);
      lateValid = 1'b0; wbValid = 1'b0;
      tick(1);
      check_wr("pre_rst", 1'b1, 5'd15, 32'hD0);
      #2 reset = 1'b1;
      #1;
      check_wr("async_rst", 1'b0, 5'd0, 32'h0);
      check("async_pend", 64'(rs1Pending), 64'd0);
      check("async_ready", 64'(lateReady), 64'd1);
      check("async_stall", 64'(wbStall), 64'd0);
      tick(2);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check($sformatf("post_rst_we%0d", i), 64'(WriteEn), 64'd0);
      end
      check("post_rst_pend", 64'(rs1Pending), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
